shift_scheduler: RTL and testbench
==================================

# shift_scheduler

Shares one `shifter` datapath between two requesters. Requests arrive on independent valid/ready ports. A round-robin arbiter grants one at a time. The operands are registered and the shift is sequenced through the shifter with `i_start`. The result is returned on a single response port with backpressure and a requester ID. The block sits between the ALU issue logic and the shifter so that two issue sources never drive the shifter at once.

## Interface
- `WIDTH`, 32, data width; passed to the shifter.
- `SHIFT_WIDTH`, 5, shift-amount width; passed to the shifter.
- `OPS`, 2, op-code width; encodings are `LEFT_SHIFTA`=00, `LEFT_SHIFTL`=01, `RIGHT_SHIFTA`=10, `RIGHT_SHIFTL`=11.
- `i_clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `i_rst` input, 1 bit: asynchronous, active-high reset.
- `i_req0_valid`, `i_req1_valid` input, 1 bit each: request present.
- `i_req0_data`, `i_req1_data` input, `WIDTH` bits: operand.
- `i_req0_shift`, `i_req1_shift` input, `SHIFT_WIDTH` bits: shift amount.
- `i_req0_op`, `i_req1_op` input, `OPS` bits: operation.
- `o_req0_ready`, `o_req1_ready` output, 1 bit each: the request is accepted this cycle.
- `o_rsp_valid` output, 1 bit: a result is pending.
- `o_rsp_data` output, `WIDTH` bits: the shift result.
- `o_rsp_id` output, 1 bit: the requester that issued the operation.
- `i_rsp_ready` input, 1 bit: the consumer accepts the result.

## Operation
- FSM states: `IDLE`, `SHIFT`, `RESP`. Reset state is `IDLE`.
- **`IDLE`**
  - Grant rule: with one valid request, grant it. With both valid, grant requester `ptr`.
  - `o_reqK_ready` is combinational: `state==IDLE && i_reqK_valid && granted K`. At most one ready is high per cycle.
  - On accept: latch data, shift, op and ID into the operand register; go to `SHIFT`.
- **`SHIFT`**
  - Drive the shifter from the operand register with `i_start=1`. `i_start` is 0 in every other state.
  - Capture the shifter output into the result register at the clock edge; go to `RESP`.
- **`RESP`**
  - `o_rsp_valid=1`. `o_rsp_data` and `o_rsp_id` are held stable until handshake.
  - On `i_rsp_ready`: set `ptr` to the inverse of the served ID; go to `IDLE`.
- `ptr` resets to 0 and changes only on response handshake.
- Result semantics:
  - Left shifts (00 and 01) fill with zeros.
  - `RIGHT_SHIFTL` fills with zeros.
  - `RIGHT_SHIFTA` fills with `data[WIDTH-1]`.
  - A shift amount of 0 returns the data unchanged.
- Requests not granted stay pending. Requesters must hold valid and operands stable until ready.
- Op codes outside the four listed encodings do not exist, since `OPS`=2 covers all of them.

## Timing
- Reset values:
  - `o_rsp_valid=0`, `o_rsp_data=0`, `o_rsp_id=0`.
  - `o_req0_ready=0`, `o_req1_ready=0` (forced while `i_rst` is high).
  - `ptr=0`, operand register 0.
- Latency: accept at cycle T, `o_rsp_valid` high from cycle T+2.
- Throughput: at best one operation per 3 cycles with `i_rsp_ready` held high. No request is accepted while in `SHIFT` or `RESP`.
- Backpressure: `RESP` is held indefinitely while `i_rsp_ready=0`. There is no timeout.
- A simultaneous request from the just-served requester and the other requester in the `IDLE` cycle after handshake grants the other requester.
- `i_rsp_ready` asserted outside `RESP` is ignored.
- Reset asserted in any state aborts the in-flight operation: no response is produced, outputs go to reset values immediately, and `ptr` returns to 0.

## Structure
- Shared package/header holds `WIDTH`, `SHIFT_WIDTH` and `OPS` defaults, the four op encodings, and the FSM state encodings (`ST_IDLE`, `ST_SHIFT`, `ST_RESP`, 2 bits).
- One sub-module: a single instance of the existing `shifter`, fed only from the operand register.
- Arbitration (2-way round-robin) is inline, not a separate module.

## Test plan
- **Reset:** assert `i_rst` mid-`SHIFT` with req0 data=0x0000_00F0. Required: `o_rsp_valid` stays 0, and no response appears after release.
- **Single request:** req0 data=0x8000_0001, shift=4, op=10. Required: `o_req0_ready` high at T; at T+2 `o_rsp_valid=1`, data=0xF800_0000, id=0.
- **Logical and left shifts:** req1 data=0x8000_0001, shift=4.
  - op=11 gives 0x0800_0000, id=1.
  - op=00 gives 0x0000_0010.
  - shift=0 returns 0x8000_0001.
- **Contention:** both valid continuously, `i_rsp_ready` held high. Required: grants alternate 0,1,0,1, with one response every 3 cycles and IDs matching.
- **Backpressure:** hold `i_rsp_ready=0` for 5 cycles in `RESP`. Required: data and ID stable, both readies 0; after `i_rsp_ready=1`, return to `IDLE` the next cycle.
- **Shift extremes:** shift=31, op=10 on 0x8000_0000 gives 0xFFFF_FFFF. Op=01 on 0x0000_0001 gives 0x8000_0000.

Source files
------------

// File: rtl/shift_scheduler_pkg.sv
// shift_scheduler_pkg: shared widths, shift op encodings and FSM state encodings
package shift_scheduler_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHIFT_WIDTH = 5;
    localparam int DEF_OPS = 2;
    localparam logic [1:0] LEFT_SHIFTA = 2'b00;
    localparam logic [1:0] LEFT_SHIFTL = 2'b01;
    localparam logic [1:0] RIGHT_SHIFTA = 2'b10;
    localparam logic [1:0] RIGHT_SHIFTL = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/shift_scheduler_if.sv
// shift_scheduler_if: two request ports plus one response port with backpressure
//   master: the two requesters and the response consumer
//   slave : the scheduler
interface shift_scheduler_if
    import shift_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int OPS = DEF_OPS
);
    logic i_req0_valid;
    logic i_req1_valid;
    logic [WIDTH-1:0] i_req0_data;
    logic [WIDTH-1:0] i_req1_data;
    logic [SHIFT_WIDTH-1:0] i_req0_shift;
    logic [SHIFT_WIDTH-1:0] i_req1_shift;
    logic [OPS-1:0] i_req0_op;
    logic [OPS-1:0] i_req1_op;
    logic o_req0_ready;
    logic o_req1_ready;
    logic o_rsp_valid;
    logic [WIDTH-1:0] o_rsp_data;
    logic o_rsp_id;
    logic i_rsp_ready;

    modport slave (
        input i_req0_valid, i_req1_valid, i_req0_data, i_req1_data,
              i_req0_shift, i_req1_shift, i_req0_op, i_req1_op, i_rsp_ready,
        output o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_data, o_rsp_id
    );

    modport master (
        output i_req0_valid, i_req1_valid, i_req0_data, i_req1_data,
               i_req0_shift, i_req1_shift, i_req0_op, i_req1_op, i_rsp_ready,
        input o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_data, o_rsp_id
    );
endinterface

// File: rtl/shifter.sv
// shifter: combinational barrel shifter, output is zero unless i_start is high
//   i_start: enable, i_data/i_shift/i_op: operand, amount and operation, o_data: result
module shifter
    import shift_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int OPS = DEF_OPS
) (
    input  logic                   i_start,
    input  logic [WIDTH-1:0]       i_data,
    input  logic [SHIFT_WIDTH-1:0] i_shift,
    input  logic [OPS-1:0]         i_op,
    output logic [WIDTH-1:0]       o_data
);
    // kept in its own signed net so the unsigned ternary below cannot turn >>> logical
    logic signed [WIDTH-1:0] asr;

    always_comb asr = $signed(i_data) >>> i_shift;

    always_comb
        o_data = !i_start ? '0 :
                 i_op == RIGHT_SHIFTA ? asr :
                 i_op == RIGHT_SHIFTL ? i_data >> i_shift :
                 i_data << i_shift;
endmodule

// File: rtl/shift_scheduler.sv
// shift_scheduler: round-robin share of one shifter between two requesters
//   i_clk, i_rst (async, active high)
//   bus.slave: req0/req1 valid/ready + operand, response valid/ready + data + id
module shift_scheduler
    import shift_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int OPS = DEF_OPS
) (
    input logic i_clk,
    input logic i_rst,
    shift_scheduler_if.slave bus
);
    state_t state, state_nx;
    logic ptr, grant1, start, op_id, res_id;
    logic [WIDTH-1:0] op_data, res_data, sh_out;
    logic [SHIFT_WIDTH-1:0] op_shift;
    logic [OPS-1:0] op_op;

    // req1 wins when alone or when both request and it is req1's turn
    always_comb grant1 = bus.i_req1_valid && (!bus.i_req0_valid || ptr);

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state <= ST_IDLE;
        else state <= state_nx;

    always_comb
        state_nx = state == ST_IDLE ? ((bus.i_req0_valid || bus.i_req1_valid) ? ST_SHIFT : ST_IDLE) :
                   state == ST_SHIFT ? ST_RESP :
                   bus.i_rsp_ready ? ST_IDLE : ST_RESP;

    always_comb begin
        bus.o_req0_ready = !i_rst && state == ST_IDLE && bus.i_req0_valid && !grant1;
        bus.o_req1_ready = !i_rst && state == ST_IDLE && grant1;
        bus.o_rsp_valid = state == ST_RESP;
        bus.o_rsp_data = res_data;
        bus.o_rsp_id = res_id;
        start = state == ST_SHIFT;
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            ptr <= 1'b0;
            op_data <= '0;
            op_shift <= '0;
            op_op <= '0;
            op_id <= 1'b0;
            res_data <= '0;
            res_id <= 1'b0;
        end else begin
            if (bus.o_req0_ready || bus.o_req1_ready) begin
                op_data <= grant1 ? bus.i_req1_data : bus.i_req0_data;
                op_shift <= grant1 ? bus.i_req1_shift : bus.i_req0_shift;
                op_op <= grant1 ? bus.i_req1_op : bus.i_req0_op;
                op_id <= grant1;
            end
            if (start) begin
                res_data <= sh_out;
                res_id <= op_id;
            end
            if (bus.o_rsp_valid && bus.i_rsp_ready) ptr <= !res_id;
        end

    shifter #(.WIDTH(WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH), .OPS(OPS)) u_shifter (
        .i_start(start),
        .i_data(op_data),
        .i_shift(op_shift),
        .i_op(op_op),
        .o_data(sh_out)
    );
endmodule

// File: tb/tb_shift_scheduler.sv
// tb_shift_scheduler: directed scoreboard bench for shift_scheduler
module tb_shift_scheduler;
    typedef struct packed {
        logic [31:0] data;
        logic        id;
    } exp_t;

    logic clk, rst;
    int vec = 0;
    int errs = 0;
    exp_t sb[$];

    shift_scheduler_if bus();

    shift_scheduler dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(logic [31:0] d, logic [4:0] s, logic [1:0] op);
        logic [31:0] r;
        int k;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            k = op[1] ? i + int'(s) : i - int'(s);
            if (!op[1]) r[i] = (k >= 0) ? d[k] : 1'b0;
            else r[i] = (k < 32) ? d[k] : (op[0] ? 1'b0 : d[31]);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // settle, update scoreboard from handshakes seen this cycle, advance one cycle
    task automatic step();
        exp_t e;
        #1;
        check("one_ready", 32'(bus.o_req0_ready & bus.o_req1_ready), 0);
        if (bus.o_req0_ready) sb.push_back('{model(bus.i_req0_data, bus.i_req0_shift, bus.i_req0_op), 1'b0});
        if (bus.o_req1_ready) sb.push_back('{model(bus.i_req1_data, bus.i_req1_shift, bus.i_req1_op), 1'b1});
        if (bus.o_rsp_valid && bus.i_rsp_ready) begin
            vec++;
            assert (sb.size() != 0) else begin
                errs++;
                $error("FAIL unexpected_rsp: observed data %h expected no response", bus.o_rsp_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_data", bus.o_rsp_data, e.data);
                check("sb_id", 32'(bus.o_rsp_id), 32'(e.id));
            end
        end
        @(negedge clk);
    endtask

    task automatic do_op(input bit p, input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] o, input logic [31:0] exp);
        if (p) begin
            bus.i_req1_valid = 1; bus.i_req1_data = d; bus.i_req1_shift = s; bus.i_req1_op = o;
        end else begin
            bus.i_req0_valid = 1; bus.i_req0_data = d; bus.i_req0_shift = s; bus.i_req0_op = o;
        end
        bus.i_rsp_ready = 1;
        #1 check("accept", 32'(p ? bus.o_req1_ready : bus.o_req0_ready), 1);
        step();
        bus.i_req0_valid = 0;
        bus.i_req1_valid = 0;
        #1 check("shift_no_rsp", 32'(bus.o_rsp_valid), 0);
        step();
        #1;
        check("rsp_valid", 32'(bus.o_rsp_valid), 1);
        check("rsp_data", bus.o_rsp_data, exp);
        check("rsp_id", 32'(bus.o_rsp_id), 32'(p));
        step();
    endtask

    initial begin
        rst = 1;
        bus.i_req0_valid = 0; bus.i_req0_data = 0; bus.i_req0_shift = 0; bus.i_req0_op = 0;
        bus.i_req1_valid = 0; bus.i_req1_data = 0; bus.i_req1_shift = 0; bus.i_req1_op = 0;
        bus.i_rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        bus.i_req0_valid = 1;
        #1;
        check("rst_ready0", 32'(bus.o_req0_ready), 0);
        check("rst_ready1", 32'(bus.o_req1_ready), 0);
        check("rst_rsp_valid", 32'(bus.o_rsp_valid), 0);
        check("rst_rsp_data", bus.o_rsp_data, 0);
        check("rst_rsp_id", 32'(bus.o_rsp_id), 0);
        @(negedge clk);
        rst = 0;
        bus.i_req0_data = 32'h0000_00F0; bus.i_req0_shift = 4; bus.i_req0_op = 2'b11;
        #1 check("abort_accept", 32'(bus.o_req0_ready), 1);
        @(negedge clk);
        bus.i_req0_valid = 0;
        rst = 1;
        #1;
        check("abort_rsp_valid", 32'(bus.o_rsp_valid), 0);
        check("abort_rsp_data", bus.o_rsp_data, 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            #1 check("abort_no_rsp", 32'(bus.o_rsp_valid), 0);
            @(negedge clk);
        end

        do_op(0, 32'h8000_0001, 4, 2'b10, 32'hF800_0000);
        do_op(1, 32'h8000_0001, 4, 2'b11, 32'h0800_0000);
        do_op(1, 32'h8000_0001, 4, 2'b00, 32'h0000_0010);
        do_op(1, 32'h8000_0001, 0, 2'b10, 32'h8000_0001);

        bus.i_req0_valid = 1; bus.i_req0_data = 32'hA5A5_0F0F; bus.i_req0_shift = 3; bus.i_req0_op = 2'b10;
        bus.i_req1_valid = 1; bus.i_req1_data = 32'h1234_5678; bus.i_req1_shift = 7; bus.i_req1_op = 2'b01;
        bus.i_rsp_ready = 1;
        for (int k = 0; k < 12; k++) begin
            #1;
            check("cont_ready0", 32'(bus.o_req0_ready), 32'(k % 3 == 0 && (k / 3) % 2 == 0));
            check("cont_ready1", 32'(bus.o_req1_ready), 32'(k % 3 == 0 && (k / 3) % 2 == 1));
            check("cont_rsp_valid", 32'(bus.o_rsp_valid), 32'(k % 3 == 2));
            step();
        end
        bus.i_req0_valid = 0;
        bus.i_req1_valid = 0;

        bus.i_req0_valid = 1; bus.i_req0_data = 32'hC000_0003; bus.i_req0_shift = 1; bus.i_req0_op = 2'b11;
        bus.i_rsp_ready = 0;
        step();
        bus.i_req0_valid = 0;
        step();
        bus.i_req1_valid = 1; bus.i_req1_data = 32'h0F00_00F0; bus.i_req1_shift = 8; bus.i_req1_op = 2'b00;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_valid", 32'(bus.o_rsp_valid), 1);
            check("bp_data", bus.o_rsp_data, 32'h6000_0001);
            check("bp_id", 32'(bus.o_rsp_id), 0);
            check("bp_ready0", 32'(bus.o_req0_ready), 0);
            check("bp_ready1", 32'(bus.o_req1_ready), 0);
            step();
        end
        bus.i_rsp_ready = 1;
        bus.i_req0_valid = 1;
        step();
        #1;
        check("post_hs_ready1", 32'(bus.o_req1_ready), 1);
        check("post_hs_ready0", 32'(bus.o_req0_ready), 0);
        step();
        bus.i_req0_valid = 0;
        bus.i_req1_valid = 0;
        step();
        #1 check("post_hs_rsp", bus.o_rsp_data, 32'h0000_F000);
        step();

        do_op(0, 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF);
        do_op(1, 32'h0000_0001, 31, 2'b01, 32'h8000_0000);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d;
            logic [4:0] s;
            logic [1:0] o;
            bit p;
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            o = 2'($urandom_range(0, 3));
            p = 1'($urandom_range(0, 1));
            do_op(p, d, s, o, model(d, s, o));
        end

        check("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
